mem_access_arbiter: RTL and testbench

MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

---
 rtl/mem_access_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_access_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - two-requester round-robin arbiter in front of a single-port memory
module mem_access_arbiter #(
    parameter int p = 6,
    parameter int r = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [r-1:0] addr0,
    input  logic [r-1:0] addr1,
    input  logic [p-1:0] wdata0,
    input  logic [p-1:0] wdata1,
    output logic [1:0]   gnt,
    output logic         ack0,
    output logic         ack1,
    output logic [p-1:0] rdata,
    output logic         wr_en,
    output logic [r-1:0] wr_addr,
    output logic [p-1:0] data_in,
    output logic         rd_en,
    output logic [r-1:0] rd_addr,
    input  logic [p-1:0] data_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        RWAIT = 3'd3,
        ACK   = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           ptr;
    logic           who;
    logic           lat_we;
    logic [r-1:0]   lat_addr;
    logic [p-1:0]   lat_wdata;
    logic [p-1:0]   rdata_q;
    logic           any_req;
    logic           win;
    logic           win_we;

    // Round-robin pick: the favoured side wins a tie, a lone requester always wins.
    always_comb begin
        any_req = req0 | req1;
        win     = (req0 & req1) ? ptr : req1;
        win_we  = win ? we1 : we0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; requests are only looked at while idle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = win_we ? WRITE : READ;
            WRITE:   state_nxt = ACK;
            READ:    state_nxt = RWAIT;
            RWAIT:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch at grant, read-data capture, and priority update on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 1'b0;
            who       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                who       <= win;
                lat_we    <= win_we;
                lat_addr  <= win ? addr1 : addr0;
                lat_wdata <= win ? wdata1 : wdata0;
            end
            if (state == RWAIT) begin
                rdata_q <= data_out;
            end
            if (state == ACK) begin
                ptr <= ~who;
            end
        end
    end

    // Outputs decoded from the current state; everything idles at zero.
    always_comb begin
        gnt     = 2'b00;
        ack0    = 1'b0;
        ack1    = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        data_in = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        if (state != IDLE) begin
            gnt = who ? 2'b10 : 2'b01;
        end
        case (state)
            WRITE: begin
                wr_en   = 1'b1;
                wr_addr = lat_addr;
                data_in = lat_wdata;
            end
            READ: begin
                rd_en   = 1'b1;
                rd_addr = lat_addr;
            end
            ACK: begin
                ack0 = ~who;
                ack1 = who;
            end
            default: begin
            end
        endcase
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - self-checking bench for mem_access_arbiter
module tb_mem_access_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [4:0] addr0, addr1;
    logic [5:0] wdata0, wdata1;
    logic [1:0] gnt;
    logic       ack0, ack1;
    logic [5:0] rdata;
    logic       wr_en, rd_en;
    logic [4:0] wr_addr, rd_addr;
    logic [5:0] data_in, data_out;

    int total = 0;
    int bad = 0;

    // Reference model state
    bit         m_ptr;
    logic [5:0] m_last;
    logic [5:0] refmem [32];

    // Memory environment
    logic [5:0] mem [32];

    always #5 clk = ~clk;

    mem_access_arbiter #(.p(6), .r(5)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .data_out(data_out)
    );

    // Synchronous memory with one-cycle read latency, preloaded during reset
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 6'(i * 5 + 3);
        end else begin
            if (wr_en) mem[wr_addr] <= data_in;
            if (rd_en) data_out <= mem[rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_ack"}, {ack1, ack0}, 0);
        chk({tag, "_strobes"}, {wr_en, rd_en}, 0);
        chk({tag, "_addrs"}, {wr_addr, rd_addr, data_in}, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    // One complete transaction: drive, follow cycle by cycle, check against the model.
    task automatic run_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                           input logic [4:0] a0, input logic [4:0] a1,
                           input logic [5:0] d0, input logic [5:0] d1, input int mut_k);
        bit         win, is_w;
        logic [4:0] a;
        logic [5:0] d;
        int         lat;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        win  = (r0 && r1) ? m_ptr : r1;
        is_w = win ? w1 : w0;
        a    = win ? a1 : a0;
        d    = win ? d1 : d0;
        lat  = is_w ? 2 : 3;
        for (int k = 1; k <= lat; k++) begin
            tick();
            chk("wr_en", wr_en, (is_w && k == 1));
            chk("rd_en", rd_en, (!is_w && k == 1));
            chk("wr_addr", wr_addr, (is_w && k == 1) ? a : 5'd0);
            chk("data_in", data_in, (is_w && k == 1) ? d : 6'd0);
            chk("rd_addr", rd_addr, (!is_w && k == 1) ? a : 5'd0);
            chk("gnt", gnt, win ? 2'b10 : 2'b01);
            if (k == lat) begin
                chk("ack", {ack1, ack0}, win ? 2'b10 : 2'b01);
                chk("rdata", rdata, is_w ? m_last : refmem[a]);
            end else begin
                chk("early_ack", {ack1, ack0}, 0);
            end
            if (k == mut_k) begin
                addr0 = 5'($urandom); addr1 = 5'($urandom);
                wdata0 = 6'($urandom); wdata1 = 6'($urandom);
                if (win) req1 = 1'($urandom); else req0 = 1'($urandom);
            end
        end
        if (is_w) refmem[a] = d; else m_last = refmem[a];
        m_ptr = ~win;
        req0 = 0; req1 = 0;
        tick();
        chk("idle_gnt", gnt, 0);
        chk("idle_ack", {ack1, ack0}, 0);
    endtask

    initial begin
        int  n_ack;
        bit  exp_id;
        bit  r0, r1;
        for (int i = 0; i < 32; i++) refmem[i] = 6'(i * 5 + 3);
        m_ptr = 0; m_last = 0;

        // Reset with both requesters already asking (continuous writes to 1 and 2)
        rst = 1; req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        addr0 = 5'd1; addr1 = 5'd2; wdata0 = 6'd17; wdata1 = 6'd42;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all_zero("reset");
        end
        rst = 0;

        // Continuous contention: strict alternation starting with requester 0
        n_ack = 0; exp_id = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            chk("ack_excl", ack0 & ack1, 0);
            if (ack0 || ack1) begin
                chk("rr_ack", {ack1, ack0}, exp_id ? 2'b10 : 2'b01);
                chk("rr_gnt", gnt, exp_id ? 2'b10 : 2'b01);
                if (exp_id) refmem[2] = 6'd42; else refmem[1] = 6'd17;
                exp_id = ~exp_id;
                n_ack++;
            end
        end
        chk("rr_count", n_ack, 8);
        req0 = 0; req1 = 0;
        m_ptr = exp_id;
        tick();

        // Requester 0 writes 31 <- 10, then reads it back
        run_txn(1, 0, 1, 0, 5'd31, 5'd0, 6'd10, 6'd0, 0);
        run_txn(1, 0, 0, 0, 5'd31, 5'd0, 6'd0, 6'd0, 0);
        chk("read_back_31", rdata, 6'd10);
        chk("mem_31", mem[31], 6'd10);

        // Read of addr 5 with req/addr disturbed during RWAIT
        run_txn(0, 1, 0, 0, 5'd0, 5'd5, 6'd0, 6'd0, 2);

        // Reset in the RWAIT cycle of a read
        req0 = 1; we0 = 0; addr0 = 5'd7;
        tick();
        chk("abort_read_cycle", rd_en, 1);
        tick();
        rst = 1; req0 = 0;
        tick();
        chk_all_zero("abort");
        rst = 0;
        m_ptr = 0; m_last = 0;
        for (int i = 0; i < 32; i++) refmem[i] = 6'(i * 5 + 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_ack", {ack1, ack0}, 0);
        end

        // Requester 1 alone against a pointer favouring requester 0
        run_txn(0, 1, 1, 1, 5'd3, 5'd9, 6'd1, 6'd33, 0);
        run_txn(0, 1, 0, 0, 5'd0, 5'd9, 6'd0, 6'd0, 0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            r0 = 1'($urandom); r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1;
            run_txn(r0, r1, 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                    6'($urandom), 6'($urandom), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
